// File: rtl/video_timing_gen_pkg.sv
// Shared types and reference timings for the raster timing generator.
// Timing bundles let callers derive parameter sets from a single named mode.
package video_pkg;

  typedef enum logic [1:0] {
    BORDER  = 2'd0,
    BARS    = 2'd1,
    CHECKER = 2'd2,
    SOLID   = 2'd3
  } pattern_mode_e;

  typedef struct packed {
    int unsigned active;
    int unsigned front;
    int unsigned sync;
    int unsigned back;
  } axis_timing_t;

  typedef struct packed {
    axis_timing_t h;
    axis_timing_t v;
  } timing_t;

  localparam timing_t Vga640x480 = '{
    h: '{active: 640, front: 16, sync: 96, back: 48},
    v: '{active: 480, front: 10, sync: 2,  back: 33}
  };

  function automatic int unsigned axis_total(axis_timing_t t);
    return t.active + t.front + t.sync + t.back;
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Video output bundle: pattern select in, raster timing, coordinates and pixel out.
interface video_timing_gen_if
  import video_pkg::*;
#(
  parameter int CntW = 11,
  parameter int PixW = 3
);
  pattern_mode_e   mode;
  logic            de;
  logic            hsync;
  logic            vsync;
  logic            sof;
  logic            eol;
  logic [CntW-1:0] x;
  logic [CntW-1:0] y;
  logic [PixW-1:0] pix;

  modport master (input mode, output de, hsync, vsync, sof, eol, x, y, pix);
  modport slave  (output mode, input de, hsync, vsync, sof, eol, x, y, pix);
endinterface

// File: rtl/video_timing_gen_counter.sv
// Column/row raster counters with active-area, sync and strobe decode.
// Everything here describes the current (unregistered) raster position.
module video_timing_counter
  import video_pkg::*;
#(
  parameter int CntW    = 11,
  parameter int HActive = 640,
  parameter int HFront  = 16,
  parameter int HSync   = 96,
  parameter int HBack   = 48,
  parameter int VActive = 480,
  parameter int VFront  = 10,
  parameter int VSync   = 2,
  parameter int VBack   = 33
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            ce_i,
  output logic [CntW-1:0] col,
  output logic [CntW-1:0] row,
  output logic            h_active,
  output logic            v_active,
  output logic            hsync_on,
  output logic            vsync_on,
  output logic            origin,
  output logic            line_end
);

  localparam int HTotal = int'(axis_total(axis_timing_t'{HActive, HFront, HSync, HBack}));
  localparam int VTotal = int'(axis_total(axis_timing_t'{VActive, VFront, VSync, VBack}));

  if (HTotal >= (1 << CntW)) begin : g_htotal_err
    $error("HTotal does not fit in CntW bits");
  end
  if (VTotal >= (1 << CntW)) begin : g_vtotal_err
    $error("VTotal does not fit in CntW bits");
  end

  localparam logic [CntW-1:0] HLast     = CntW'(HTotal - 1);
  localparam logic [CntW-1:0] VLast     = CntW'(VTotal - 1);
  localparam logic [CntW-1:0] HAct      = CntW'(HActive);
  localparam logic [CntW-1:0] VAct      = CntW'(VActive);
  localparam logic [CntW-1:0] HActLast  = CntW'(HActive - 1);
  localparam logic [CntW-1:0] HSyncBeg  = CntW'(HActive + HFront);
  localparam logic [CntW-1:0] HSyncEnd  = CntW'(HActive + HFront + HSync);
  localparam logic [CntW-1:0] VSyncBeg  = CntW'(VActive + VFront);
  localparam logic [CntW-1:0] VSyncEnd  = CntW'(VActive + VFront + VSync);

  logic [CntW-1:0] col_reg, col_next;
  logic [CntW-1:0] row_reg, row_next;

  always_comb begin
    col_next = col_reg;
    row_next = row_reg;
    if (ce_i) begin
      if (col_reg == HLast) begin
        col_next = '0;
        row_next = (row_reg == VLast) ? '0 : row_reg + CntW'(1);
      end else begin
        col_next = col_reg + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      col_reg <= '0;
      row_reg <= '0;
    end else begin
      col_reg <= col_next;
      row_reg <= row_next;
    end
  end

  // vsync is purely a row decode, so it flips together with the row at col 0.
  assign col      = col_reg;
  assign row      = row_reg;
  assign h_active = (col_reg < HAct);
  assign v_active = (row_reg < VAct);
  assign hsync_on = (col_reg >= HSyncBeg) && (col_reg < HSyncEnd);
  assign vsync_on = (row_reg >= VSyncBeg) && (row_reg < VSyncEnd);
  assign origin   = (col_reg == '0) && (row_reg == '0);
  assign line_end = (col_reg == HActLast) && v_active;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator with run-time selectable test pattern.
// One output register stage, advanced only on ce_i, so outputs lag the counters by one ce cycle.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int   CntW      = 11,
  parameter int   HActive   = int'(Vga640x480.h.active),
  parameter int   HFront    = int'(Vga640x480.h.front),
  parameter int   HSync     = int'(Vga640x480.h.sync),
  parameter int   HBack     = int'(Vga640x480.h.back),
  parameter int   VActive   = int'(Vga640x480.v.active),
  parameter int   VFront    = int'(Vga640x480.v.front),
  parameter int   VSync     = int'(Vga640x480.v.sync),
  parameter int   VBack     = int'(Vga640x480.v.back),
  parameter logic HSyncPol  = 1'b0,
  parameter logic VSyncPol  = 1'b0,
  parameter int   PixW      = 3,
  parameter int   CheckLog2 = 4
) (
  input logic                clk_i,
  input logic                rst_i,
  input logic                ce_i,
  video_timing_gen_if.master vid
);

  if ((HActive % 8) != 0) begin : g_hactive_err
    $error("HActive must be divisible by 8");
  end
  if (CheckLog2 >= CntW) begin : g_check_err
    $error("CheckLog2 must index a counter bit");
  end

  localparam logic [CntW-1:0] BarLast  = CntW'(HActive / 8 - 1);
  localparam logic [CntW-1:0] HActLast = CntW'(HActive - 1);
  localparam logic [CntW-1:0] VActLast = CntW'(VActive - 1);

  logic [CntW-1:0] col, row;
  logic            h_active, v_active, hsync_on, vsync_on, origin, line_end;

  video_timing_counter #(
    .CntW(CntW), .HActive(HActive), .HFront(HFront), .HSync(HSync), .HBack(HBack),
    .VActive(VActive), .VFront(VFront), .VSync(VSync), .VBack(VBack)
  ) u_counter (
    .clk_i(clk_i), .rst_i(rst_i), .ce_i(ce_i),
    .col(col), .row(row), .h_active(h_active), .v_active(v_active),
    .hsync_on(hsync_on), .vsync_on(vsync_on), .origin(origin), .line_end(line_end)
  );

  pattern_mode_e   mode_reg, mode_next, mode_eff;
  logic [CntW-1:0] bar_pos_reg, bar_pos_next;
  logic [2:0]      bar_idx_reg, bar_idx_next;
  logic [PixW-1:0] pix_bar, pix_next;
  logic            active, check_bit;

  logic            de_reg, hsync_reg, vsync_reg, sof_reg, eol_reg;
  logic [CntW-1:0] x_reg, y_reg;
  logic [PixW-1:0] pix_reg;

  // The first pixel of a frame already uses the newly sampled mode.
  assign mode_eff  = origin ? vid.mode : mode_reg;
  assign active    = h_active && v_active;
  assign check_bit = col[CheckLog2] ^ row[CheckLog2];

  always_comb begin
    mode_next = mode_reg;
    if (ce_i && origin) begin
      mode_next = vid.mode;
    end
  end

  // Bar position runs along every line and is cleared throughout blanking.
  always_comb begin
    bar_pos_next = bar_pos_reg;
    bar_idx_next = bar_idx_reg;
    if (ce_i) begin
      if (!h_active) begin
        bar_pos_next = '0;
        bar_idx_next = '0;
      end else if (bar_pos_reg == BarLast) begin
        bar_pos_next = '0;
        bar_idx_next = bar_idx_reg + 3'd1;
      end else begin
        bar_pos_next = bar_pos_reg + CntW'(1);
      end
    end
  end

  genvar gi;
  for (gi = 0; gi < PixW; gi++) begin : g_bar_bits
    if (gi < 3) begin : g_idx
      assign pix_bar[gi] = bar_idx_reg[gi];
    end else begin : g_pad
      assign pix_bar[gi] = 1'b0;
    end
  end

  always_comb begin
    pix_next = '0;
    if (active) begin
      case (mode_eff)
        BORDER:  if (row == '0 || row == VActLast || col == '0 || col == HActLast) pix_next = '1;
        BARS:    pix_next = pix_bar;
        CHECKER: pix_next = {PixW{check_bit}};
        SOLID:   pix_next = '1;
        default: pix_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mode_reg    <= BORDER;
      bar_pos_reg <= '0;
      bar_idx_reg <= '0;
      de_reg      <= 1'b0;
      hsync_reg   <= ~HSyncPol;
      vsync_reg   <= ~VSyncPol;
      sof_reg     <= 1'b0;
      eol_reg     <= 1'b0;
      x_reg       <= '0;
      y_reg       <= '0;
      pix_reg     <= '0;
    end else begin
      mode_reg    <= mode_next;
      bar_pos_reg <= bar_pos_next;
      bar_idx_reg <= bar_idx_next;
      if (ce_i) begin
        de_reg    <= active;
        hsync_reg <= hsync_on ? HSyncPol : ~HSyncPol;
        vsync_reg <= vsync_on ? VSyncPol : ~VSyncPol;
        sof_reg   <= origin;
        eol_reg   <= line_end;
        x_reg     <= col;
        y_reg     <= row;
        pix_reg   <= pix_next;
      end else begin
        // Strobes are one clk wide even when ce_i runs at a fraction of clk_i.
        sof_reg <= 1'b0;
        eol_reg <= 1'b0;
      end
    end
  end

  assign vid.de    = de_reg;
  assign vid.hsync = hsync_reg;
  assign vid.vsync = vsync_reg;
  assign vid.sof   = sof_reg;
  assign vid.eol   = eol_reg;
  assign vid.x     = x_reg;
  assign vid.y     = y_reg;
  assign vid.pix   = pix_reg;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a default 640x480 instance and a tiny active-high-sync instance,
// both checked every cycle against a raster-position model plus directed literal expectations.
module tb_video_timing_gen;
  import video_pkg::*;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic        sof;
    logic        eol;
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  pix;
  } exp_t;

  localparam int ATot = 800 * 525;
  localparam int BTot = 12 * 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, rst_b = 1'b1, ce_a = 1'b0, ce_b = 1'b0;
  bit   cmp_en = 1'b0;
  int   n_checks = 0, n_errors = 0;

  video_timing_gen_if #(.CntW(11), .PixW(3)) if_a ();
  video_timing_gen_if #(.CntW(11), .PixW(3)) if_b ();

  video_timing_gen dut_a (.clk_i(clk), .rst_i(rst_a), .ce_i(ce_a), .vid(if_a));

  video_timing_gen #(
    .HActive(8), .HFront(1), .HSync(2), .HBack(1),
    .VActive(4), .VFront(1), .VSync(1), .VBack(1),
    .HSyncPol(1'b1), .VSyncPol(1'b1), .CheckLog2(1)
  ) dut_b (.clk_i(clk), .rst_i(rst_b), .ce_i(ce_b), .vid(if_b));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected registered outputs for raster position p (pixels since frame start).
  function automatic exp_t model_out(int p, int mode, int ha, int hf, int hsw, int hb,
                                     int va, int vf, int vsw, bit hpol, bit vpol, int chk);
    exp_t e;
    int   ht, col, row;
    ht = ha + hf + hsw + hb;
    col = p % ht;
    row = p / ht;
    e.de  = (col < ha) && (row < va);
    e.hs  = (col >= ha + hf && col < ha + hf + hsw) ? hpol : ~hpol;
    e.vs  = (row >= va + vf && row < va + vf + vsw) ? vpol : ~vpol;
    e.sof = (p == 0);
    e.eol = (col == ha - 1) && (row < va);
    e.x   = 16'(col);
    e.y   = 16'(row);
    e.pix = 8'd0;
    if (e.de) begin
      case (mode)
        0:       e.pix = (row == 0 || row == va - 1 || col == 0 || col == ha - 1) ? 8'd7 : 8'd0;
        1:       e.pix = 8'((col / (ha / 8)) & 7);
        2:       e.pix = ((((col >> chk) ^ (row >> chk)) & 1) != 0) ? 8'd7 : 8'd0;
        default: e.pix = 8'd7;
      endcase
    end
    return e;
  endfunction

  function automatic exp_t reset_exp(bit hpol, bit vpol);
    exp_t e;
    e = '0;
    e.hs = ~hpol;
    e.vs = ~vpol;
    return e;
  endfunction

  int   pa, ma, pb, mb;
  exp_t ea, eb, act_a, act_b;

  always @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      pa <= 0; ma <= 0; ea <= reset_exp(1'b0, 1'b0);
    end else if (ce_a) begin
      ea <= model_out(pa, (pa == 0) ? int'(if_a.mode) : ma, 640, 16, 96, 48, 480, 10, 2, 1'b0, 1'b0, 4);
      pa <= (pa + 1) % ATot;
      if (pa == 0) ma <= int'(if_a.mode);
    end else begin
      ea.sof <= 1'b0; ea.eol <= 1'b0;
    end
  end

  always @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      pb <= 0; mb <= 0; eb <= reset_exp(1'b1, 1'b1);
    end else if (ce_b) begin
      eb <= model_out(pb, (pb == 0) ? int'(if_b.mode) : mb, 8, 1, 2, 1, 4, 1, 1, 1'b1, 1'b1, 1);
      pb <= (pb + 1) % BTot;
      if (pb == 0) mb <= int'(if_b.mode);
    end else begin
      eb.sof <= 1'b0; eb.eol <= 1'b0;
    end
  end

  task automatic cmp_vid(input string tag, input exp_t act, input exp_t exp);
    check({tag, ".de"},    32'(act.de),  32'(exp.de));
    check({tag, ".hsync"}, 32'(act.hs),  32'(exp.hs));
    check({tag, ".vsync"}, 32'(act.vs),  32'(exp.vs));
    check({tag, ".sof"},   32'(act.sof), 32'(exp.sof));
    check({tag, ".eol"},   32'(act.eol), 32'(exp.eol));
    check({tag, ".x"},     32'(act.x),   32'(exp.x));
    check({tag, ".y"},     32'(act.y),   32'(exp.y));
    check({tag, ".pix"},   32'(act.pix), 32'(exp.pix));
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      act_a = '{de: if_a.de, hs: if_a.hsync, vs: if_a.vsync, sof: if_a.sof, eol: if_a.eol,
                x: 16'(if_a.x), y: 16'(if_a.y), pix: 8'(if_a.pix)};
      act_b = '{de: if_b.de, hs: if_b.hsync, vs: if_b.vsync, sof: if_b.sof, eol: if_b.eol,
                x: 16'(if_b.x), y: 16'(if_b.y), pix: 8'(if_b.pix)};
      cmp_vid("a", act_a, ea);
      cmp_vid("b", act_b, eb);
    end
  end

  // Returns on the negedge where dut_b shows (x, y).
  task automatic wait_b(input int x, input int y, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (int'(if_b.x) == x && int'(if_b.y) == y) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int de_cnt, hs_cnt, hs_first, eol_cnt, sof_b_cnt, vs_b_cnt, hs_b_cnt, hs_b_first;
    int p79, p80, p639, p00, p160, p1616, dbl, sof_seen;
    bit prev_sof, prev_eol, found;

    if_a.mode = BARS;
    if_b.mode = BORDER;
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_a.hsync", 32'(if_a.hsync), 1);
    check("rst_a.vsync", 32'(if_a.vsync), 1);
    check("rst_b.hsync", 32'(if_b.hsync), 0);
    check("rst_b.vsync", 32'(if_b.vsync), 0);
    check("rst_a.de",    32'(if_a.de),    0);
    $display("reset: a.hsync=%0b b.hsync=%0b", if_a.hsync, if_b.hsync);

    #1 rst_a = 1'b0; rst_b = 1'b0; ce_a = 1'b1; ce_b = 1'b1;
    @(negedge clk);
    check("a.first_sof", 32'(if_a.sof), 1);
    check("b.first_sof", 32'(if_b.sof), 1);

    de_cnt = 0; hs_cnt = 0; hs_first = -1; eol_cnt = 0;
    sof_b_cnt = 0; vs_b_cnt = 0; hs_b_cnt = 0; hs_b_first = -1;
    p79 = -1; p80 = -1; p639 = -1;
    for (int i = 0; i < 800; i++) begin
      if (if_a.de) de_cnt++;
      if (!if_a.hsync) begin
        if (hs_first < 0) hs_first = i;
        hs_cnt++;
      end
      if (if_a.eol) eol_cnt++;
      if (if_a.de && if_a.y == 11'd0) begin
        if (if_a.x == 11'd79)  p79  = int'(if_a.pix);
        if (if_a.x == 11'd80)  p80  = int'(if_a.pix);
        if (if_a.x == 11'd639) p639 = int'(if_a.pix);
      end
      if (if_b.sof) sof_b_cnt++;
      if (if_b.vsync) vs_b_cnt++;
      if (if_b.hsync) begin
        if (hs_b_first < 0) hs_b_first = i;
        hs_b_cnt++;
      end
      @(negedge clk);
    end
    check("a.line_de_clks", de_cnt, 640);
    check("a.hsync_width", hs_cnt, 96);
    check("a.hsync_start", hs_first, 656);
    check("a.eol_count", eol_cnt, 1);
    check("a.bar_x79", p79, 0);
    check("a.bar_x80", p80, 1);
    check("a.bar_x639", p639, 7);
    check("b.sof_count", sof_b_cnt, 10);
    check("b.vsync_clks", vs_b_cnt, 108);
    check("b.hsync_clks", hs_b_cnt, 132);
    check("b.hsync_start", hs_b_first, 9);
    $display("line scan: de=%0d hs=%0d@%0d bars=%0d/%0d/%0d b.sof=%0d", de_cnt, hs_cnt, hs_first,
             p79, p80, p639, sof_b_cnt);

    #1 rst_a = 1'b1; if_a.mode = CHECKER;
    #1 check("a.async_rst_x", 32'(if_a.x), 0);
    @(negedge clk);
    #1 rst_a = 1'b0;
    @(negedge clk);
    check("a.rst_sof", 32'(if_a.sof), 1);
    check("a.rst_y", 32'(if_a.y), 0);

    p00 = -1; p160 = -1; p1616 = -1; found = 1'b0; dbl = 0; sof_seen = 0;
    prev_sof = 1'b0; prev_eol = 1'b0;
    for (int i = 0; i < 14000; i++) begin
      if (if_a.de) begin
        if (if_a.x == 11'd0  && if_a.y == 11'd0)  p00   = int'(if_a.pix);
        if (if_a.x == 11'd16 && if_a.y == 11'd0)  p160  = int'(if_a.pix);
        if (if_a.x == 11'd16 && if_a.y == 11'd16) p1616 = int'(if_a.pix);
      end
      if (if_b.sof) sof_seen++;
      if ((if_b.sof && prev_sof) || (if_b.eol && prev_eol)) dbl++;
      prev_sof = if_b.sof;
      prev_eol = if_b.eol;
      if (if_a.y == 11'd17) begin
        found = 1'b1;
        break;
      end
      #1 ce_b = ~ce_b;
      @(negedge clk);
    end
    check("a.scan_done", 32'(found), 1);
    check("a.chk_0_0", p00, 0);
    check("a.chk_16_0", p160, 7);
    check("a.chk_16_16", p1616, 0);
    check("b.strobe_width", dbl, 0);
    check("b.sof_seen", 32'(sof_seen > 0), 1);
    $display("checker scan: (0,0)=%0d (16,0)=%0d (16,16)=%0d b.sof=%0d", p00, p160, p1616, sof_seen);

    #1 ce_b = 1'b1;
    wait_b(1, 1, found);  check("b.wait_1_1", 32'(found), 1);
    #1 if_b.mode = SOLID;
    wait_b(2, 2, found);  check("b.wait_2_2", 32'(found), 1);
    check("b.mode_hold", 32'(if_b.pix), 0);
    wait_b(0, 0, found);  check("b.wait_0_0", 32'(found), 1);
    wait_b(2, 2, found);  check("b.wait_next", 32'(found), 1);
    check("b.mode_next", 32'(if_b.pix), 7);
    $display("mode switch: pix at (2,2) next frame=%0d", if_b.pix);

    wait_b(5, 2, found);  check("b.wait_5_2", 32'(found), 1);
    #1 rst_b = 1'b1; if_b.mode = CHECKER;
    #1;
    check("b.async_x", 32'(if_b.x), 0);
    check("b.async_y", 32'(if_b.y), 0);
    check("b.async_de", 32'(if_b.de), 0);
    check("b.async_pix", 32'(if_b.pix), 0);
    check("b.async_hsync", 32'(if_b.hsync), 0);
    @(negedge clk);
    #1 rst_b = 1'b0;
    @(negedge clk);
    check("b.rst_sof", 32'(if_b.sof), 1);
    check("b.rst_x", 32'(if_b.x), 0);
    check("b.rst_y", 32'(if_b.y), 0);
    wait_b(2, 0, found);  check("b.wait_2_0", 32'(found), 1);
    check("b.chk_2_0", 32'(if_b.pix), 7);
    wait_b(2, 2, found);  check("b.wait_chk_2_2", 32'(found), 1);
    check("b.chk_2_2", 32'(if_b.pix), 0);
    $display("reset recovery: b restarted at (0,0) with checker pattern");

    repeat (5) @(negedge clk);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
